// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg
//   Shared constants for the PWM duty sequencer slice: FSM state codes,
//   default datapath width and the last counter value of a default-width
//   period.
//   Optional feature macro used by the slice: PWM_SOFTSTART_EN.
package pwm_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_MAX       = (1 << DEFAULT_WIDTH) - 1;

  // State codes are observable on the state port, so the encoding is fixed.
  localparam logic [1:0] OFF   = 2'd0;
  localparam logic [1:0] RAMP  = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter
//   Free-running period counter for the PWM compare stage. It counts
//   0..LAST and wraps back to 0; clear has priority over enable.
// Ports
//   cLK    in   1      clock, rising edge
//   rST_n  in   1      synchronous reset, active-low
//   clr    in   1      force the count to 0 on the next edge
//   en     in   1      advance the count by one on the next edge
//   cnt    out  WIDTH  current count
//   wrap   out  1      high while cnt == LAST (last cycle of the period)
module pwm_period_counter
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LAST  = CNT_MAX
) (
  input  logic             cLK,
  input  logic             rST_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST_CODE = LAST[WIDTH-1:0];

  // Counter register; the natural binary rollover provides the wrap when
  // LAST is the all-ones code, which is how the sequencer uses it.
  always_ff @(posedge cLK) begin
    if (!rST_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign wrap = (cnt == LAST_CODE);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer
//   Controller for the PWM generator datapath. Owns the period counter,
//   captures ADC duty requests into a target register and moves the applied
//   duty toward it only on the last cycle of a period, so the compare stage
//   never sees a duty change mid-period. Handles soft-start/soft-stop ramping
//   and the OFF/RAMP/TRACK/DRAIN enable sequence.
// Configuration
//   PWM_SOFTSTART_EN defined  : duty moves by STEP per period.
//   PWM_SOFTSTART_EN undefined: duty jumps to its destination at the next
//                               period boundary; STEP has no effect.
// Ports
//   cLK           in   1      clock, rising edge
//   rST_n         in   1      synchronous reset, active-low
//   en            in   1      1 = run and ramp to target, 0 = drain to 0
//   adc           in   WIDTH  requested duty code
//   adc_vld       in   1      strobe: capture adc into target
//   duty          out  WIDTH  duty code applied this period
//   cnt           out  WIDTH  period counter to the compare stage
//   period_start  out  1      high on the last cycle of a period
//   at_target     out  1      duty equals target while tracking
//   state         out  2      current FSM state code
module pwm_duty_sequencer
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = 1
) (
  input  logic             cLK,
  input  logic             rST_n,
  input  logic             en,
  input  logic [WIDTH-1:0] adc,
  input  logic             adc_vld,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] cnt,
  output logic             period_start,
  output logic             at_target,
  output logic [1:0]       state
);

`ifdef PWM_SOFTSTART_EN
  localparam logic [WIDTH:0] EFF_STEP = (WIDTH+1)'(STEP);
`else
  // A full-scale step always lands on the destination in one boundary.
  // Any legal STEP fits inside the all-ones low bits, so folding it in
  // leaves the step at full scale.
  localparam logic [WIDTH:0] FULL_STEP = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] EFF_STEP  = FULL_STEP | (WIDTH+1)'(STEP);
`endif

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] dest;
  logic [WIDTH-1:0] duty_stepped;
  logic [WIDTH-1:0] duty_next;
  logic [WIDTH:0]   up_sum;
  logic [1:0]       state_next;
  logic             boundary;

  pwm_period_counter #(
    .WIDTH (WIDTH),
    .LAST  ((1 << WIDTH) - 1)
  ) u_counter (
    .cLK   (cLK),
    .rST_n (rST_n),
    .clr   (state == OFF),
    .en    (state != OFF),
    .cnt   (cnt),
    .wrap  (boundary)
  );

  assign period_start = boundary;
  assign at_target    = (state == TRACK) && (duty == target);

  // One saturating step toward the destination. The sums are one bit wider
  // than the duty so the comparison sees the true value before clamping;
  // that is what keeps the duty from overshooting or wrapping.
  assign dest   = (state == DRAIN) ? '0 : target;
  assign up_sum = {1'b0, duty} + EFF_STEP;

  always_comb begin
    duty_stepped = duty;
    if (duty < dest) begin
      duty_stepped = (up_sum > {1'b0, dest}) ? dest : up_sum[WIDTH-1:0];
    end else if (duty > dest) begin
      if ({1'b0, duty} >= ({1'b0, dest} + EFF_STEP)) begin
        duty_stepped = duty - EFF_STEP[WIDTH-1:0];
      end else begin
        duty_stepped = dest;
      end
    end
  end

  // Sequencing. Duty only changes on a boundary cycle. The en level
  // overrides whatever the boundary would have chosen, so a change of en is
  // always honoured on the very next cycle. TRACK and RAMP share one rule:
  // after stepping, the state says whether the duty has landed on target.
  always_comb begin
    state_next = state;
    duty_next  = duty;
    case (state)
      OFF: begin
        if (en) state_next = RAMP;
      end
      RAMP, TRACK: begin
        if (boundary) begin
          duty_next  = duty_stepped;
          state_next = (duty_stepped == target) ? TRACK : RAMP;
        end
        if (!en) state_next = DRAIN;
      end
      DRAIN: begin
        if (boundary) begin
          duty_next = duty_stepped;
          if (duty_stepped == '0) state_next = OFF;
        end
        if (en) state_next = RAMP;
      end
      default: state_next = OFF;
    endcase
  end

  // Target is captured on every strobe regardless of state. A strobe on a
  // boundary cycle lands after that boundary has already used the old value.
  always_ff @(posedge cLK) begin
    if (!rST_n) begin
      state  <= OFF;
      duty   <= '0;
      target <= '0;
    end else begin
      state <= state_next;
      duty  <= duty_next;
      if (adc_vld) target <= adc;
    end
  end

endmodule
